// File: rtl/oaram_encoder_pkg.sv
// ppu_pkg: definitions shared by the post-processing unit output path.
//   bw_e        - output precision select (8/4/2/1 bit)
//   enc_state_e - OARAM encoder FSM states
//   sat_max()   - largest representable unsigned value for a precision
package ppu_pkg;

  typedef enum logic [1:0] {
    BW8 = 2'd0,
    BW4 = 2'd1,
    BW2 = 2'd2,
    BW1 = 2'd3
  } bw_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } enc_state_e;

  function automatic logic [7:0] sat_max(input bw_e bw);
    case (bw)
      BW8:     return 8'hFF;
      BW4:     return 8'h0F;
      BW2:     return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

endpackage

// File: rtl/oaram_encoder_if.sv
// OARAM write port bundle.
//   oaram_value         - encoded activation
//   oaram_indices_value - zeros skipped before this value
//   oaram_address       - write address
//   oaram_write_enable  - write strobe
// master = encoder side, slave = RAM side.
interface oaram_encoder_if #(
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4
);
  logic [7:0]             oaram_value;
  logic [INDEX_WIDTH-1:0] oaram_indices_value;
  logic [RAM_WIDTH-1:0]   oaram_address;
  logic                   oaram_write_enable;

  modport master (
    output oaram_value, oaram_indices_value, oaram_address, oaram_write_enable
  );
  modport slave (
    input  oaram_value, oaram_indices_value, oaram_address, oaram_write_enable
  );
endinterface

// File: rtl/oaram_encoder_relu_quantize.sv
// relu_quantize: combinational ReLU followed by unsigned saturation.
//   d_i  - signed 8b accumulated value
//   bw_i - output precision
//   q_o  - clamp(max(d_i,0), 0, 2^w-1)
module relu_quantize
  import ppu_pkg::*;
(
  input  logic [7:0] d_i,
  input  bw_e        bw_i,
  output logic [7:0] q_o
);
  logic [7:0] r;
  logic [7:0] m;

  always_comb begin
    r   = d_i[7] ? 8'd0 : d_i;
    m   = sat_max(bw_i);
    q_o = (r > m) ? m : r;
  end
endmodule

// File: rtl/oaram_encoder.sv
// oaram_encoder: scans the accumulation buffer, applies ReLU + saturation
// and zero-run-length encodes the result into the OARAM.
//   clk, reset                 - clock, synchronous active-high reset
//   bitwidth, scan_count       - scan configuration, sampled at start
//   start                      - one-cycle launch pulse (ignored while busy)
//   buffer_bank_read/entry     - buffer read address (bank-interleaved)
//   buffer_data_read           - read data, one cycle after the address
//   wr                         - OARAM write port (interface, master side)
//   busy, done                 - scan in progress / completion pulse
//   oaram_entry_count          - writes made by the last scan
//   overflow                   - sticky OARAM capacity exceeded
// Banks and tile size are assumed to be powers of two.
module oaram_encoder
  import ppu_pkg::*;
#(
  parameter int BANK_COUNT  = 32,
  parameter int TILE_SIZE   = 128,
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4,
  localparam int BANK_W  = $clog2(BANK_COUNT),
  localparam int ENTRY_W = $clog2(TILE_SIZE),
  localparam int IDX_W   = $clog2(BANK_COUNT*TILE_SIZE),
  localparam int CNT_W   = IDX_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           bitwidth,
  input  logic                 start,
  input  logic [CNT_W-1:0]     scan_count,
  output logic [BANK_W-1:0]    buffer_bank_read,
  output logic [ENTRY_W-1:0]   buffer_bank_entry,
  input  logic [7:0]           buffer_data_read,
  oaram_encoder_if.master      wr,
  output logic                 busy,
  output logic                 done,
  output logic [RAM_WIDTH:0]   oaram_entry_count,
  output logic                 overflow
);
  localparam logic [INDEX_WIDTH-1:0] MAX_RUN = '1;
  localparam logic [RAM_WIDTH:0]     CAP     = {1'b1, {RAM_WIDTH{1'b0}}};

  enc_state_e             state_q;
  bw_e                    bw_q;
  logic [IDX_W-1:0]       idx_q, last_q;
  logic                   done_q;

  logic                   d_vld_q;
  logic [INDEX_WIDTH-1:0] run_q;
  logic [RAM_WIDTH:0]     cnt_q;
  logic                   ovf_q, we_q;
  logic [7:0]             val_q;
  logic [INDEX_WIDTH-1:0] ridx_q;
  logic [RAM_WIDTH-1:0]   addr_q;

  logic [7:0]             q;
  logic                   start_acc, wr_due;

  // Linear index i maps to bank = i mod BANK_COUNT, entry = i / BANK_COUNT.
  assign buffer_bank_read  = idx_q[BANK_W-1:0];
  assign buffer_bank_entry = idx_q[BANK_W +: ENTRY_W];

  assign busy              = (state_q != S_IDLE);
  assign done              = done_q;
  assign oaram_entry_count = cnt_q;
  assign overflow          = ovf_q;

  assign wr.oaram_write_enable  = we_q;
  assign wr.oaram_value         = val_q;
  assign wr.oaram_indices_value = ridx_q;
  assign wr.oaram_address       = addr_q;

  assign start_acc = (state_q == S_IDLE) && start;

  relu_quantize u_rq (
    .d_i  (buffer_data_read),
    .bw_i (bw_q),
    .q_o  (q)
  );

  // A zero still produces a write once the run counter is saturated,
  // so the run field never needs more than INDEX_WIDTH bits.
  assign wr_due = d_vld_q && ((q != 8'd0) || (run_q == MAX_RUN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bw_q    <= BW8;
      idx_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          bw_q   <= bw_e'(bitwidth);
          idx_q  <= '0;
          last_q <= IDX_W'(scan_count - 1'b1);
          if (scan_count == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_READ;
          end
        end
        S_READ: begin
          if (idx_q == last_q) state_q <= S_FLUSH;
          else                 idx_q   <= idx_q + 1'b1;
        end
        // Final read data arrives here; the last write lands with done.
        S_FLUSH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_vld_q <= 1'b0;
      run_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      val_q   <= '0;
      ridx_q  <= '0;
      addr_q  <= '0;
    end else begin
      d_vld_q <= (state_q == S_READ);
      we_q    <= 1'b0;
      if (start_acc) begin
        run_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (d_vld_q) begin
        if (wr_due) begin
          run_q <= '0;
          // Full RAM: drop the write but keep scanning so done still fires.
          if (cnt_q == CAP) begin
            ovf_q <= 1'b1;
          end else begin
            we_q   <= 1'b1;
            val_q  <= q;
            ridx_q <= run_q;
            addr_q <= cnt_q[RAM_WIDTH-1:0];
            cnt_q  <= cnt_q + 1'b1;
          end
        end else begin
          run_q <= run_q + 1'b1;
        end
      end
    end
  end
endmodule
